// File: rtl/audio_adc_deserializer.sv
// Serial-audio ADC receiver: oversamples BCLK/LRCK/DATA in the CLK domain,
// deserialises I2S or left-justified stereo words and presents frames on a
// valid/ready interface with sticky overrun detection.
// Optional build macro AUD_PEAK_EN adds per-channel peak-magnitude tracking.
// DATA_WIDTH must be at least 2.
module audio_adc_deserializer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned I2S_MODE    = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADC_LRCK,
  input  logic                  AUD_ADC_DATA,
  output logic [DATA_WIDTH-1:0] LEFT_DATA,
  output logic [DATA_WIDTH-1:0] RIGHT_DATA,
  output logic                  SAMPLE_VALID,
  input  logic                  SAMPLE_READY,
  output logic                  OVERRUN,
  input  logic                  OVERRUN_CLR
`ifdef AUD_PEAK_EN
  ,
  output logic [DATA_WIDTH-2:0] LEFT_PEAK,
  output logic [DATA_WIDTH-2:0] RIGHT_PEAK,
  input  logic                  PEAK_CLR
`endif
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {ALIGN, SKIP, SHIFT, WAIT} state_t;

  logic [SYNC_N-1:0]     bclk_sync, lrck_sync, data_sync;
  logic                  bclk_prev;
  logic                  lrck_prev, lrck_valid;
  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  slot_left;
  logic [DATA_WIDTH-1:0] left_stage;
  logic                  left_ok;

  logic                  bclk_s, lrck_s, data_s;
  logic                  bclk_rise_c, boundary_c;
  logic [DATA_WIDTH-1:0] shift_word_c, commit_word_c;
  logic                  commit_c, frame_c, overrun_c;

  // Input synchronisers and BCLK edge history
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      data_sync <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_N-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_N-2:0], AUD_ADC_LRCK};
      data_sync <= {data_sync[SYNC_N-2:0], AUD_ADC_DATA};
      bclk_prev <= bclk_sync[SYNC_N-1];
    end
  end

  // Edge/boundary detection and word-commit decode
  always_comb begin
    bclk_s        = bclk_sync[SYNC_N-1];
    lrck_s        = lrck_sync[SYNC_N-1];
    data_s        = data_sync[SYNC_N-1];
    bclk_rise_c   = bclk_s & ~bclk_prev;
    boundary_c    = bclk_rise_c & lrck_valid & (lrck_s != lrck_prev);
    shift_word_c  = (word_q << 1) | DATA_WIDTH'(data_s);
    commit_c      = 1'b0;
    commit_word_c = shift_word_c;
    if (bclk_rise_c && state == SHIFT) begin
      if (boundary_c) begin
        // Short slot: left-align the bits received so far, zero-filling LSBs
        commit_c      = 1'b1;
        commit_word_c = word_q << (CNT_W'(DATA_WIDTH) - bit_cnt);
      end else if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
        commit_c = 1'b1;
      end
    end
    frame_c   = commit_c & ~slot_left & left_ok;
    overrun_c = frame_c & SAMPLE_VALID & ~SAMPLE_READY;
  end

  // Slot framing FSM; the boundary bit is the I2S delay bit, or the MSB when left-justified
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= ALIGN;
      bit_cnt    <= '0;
      word_q     <= '0;
      slot_left  <= 1'b0;
      lrck_prev  <= 1'b0;
      lrck_valid <= 1'b0;
    end else if (bclk_rise_c) begin
      lrck_prev  <= lrck_s;
      lrck_valid <= 1'b1;
      if (boundary_c) begin
        slot_left <= lrck_s;
        if (I2S_MODE != 0) begin
          state   <= SKIP;
          bit_cnt <= '0;
        end else begin
          state   <= SHIFT;
          word_q  <= shift_word_c;
          bit_cnt <= CNT_W'(1);
        end
      end else begin
        case (state)
          SKIP: begin
            state   <= SHIFT;
            word_q  <= shift_word_c;
            bit_cnt <= CNT_W'(1);
          end
          SHIFT: begin
            word_q  <= shift_word_c;
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) state <= WAIT;
          end
          default: state <= state;
        endcase
      end
    end
  end

  // Channel pairing, output holding register and overrun flag
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      left_stage   <= '0;
      left_ok      <= 1'b0;
      LEFT_DATA    <= '0;
      RIGHT_DATA   <= '0;
      SAMPLE_VALID <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      if (commit_c && slot_left) begin
        left_stage <= commit_word_c;
        left_ok    <= 1'b1;
      end else if (frame_c) begin
        left_ok <= 1'b0;
      end
      if (frame_c && (!SAMPLE_VALID || SAMPLE_READY)) begin
        LEFT_DATA    <= left_stage;
        RIGHT_DATA   <= commit_word_c;
        SAMPLE_VALID <= 1'b1;
      end else if (SAMPLE_VALID && SAMPLE_READY) begin
        SAMPLE_VALID <= 1'b0;
      end
      OVERRUN <= overrun_c | (OVERRUN & ~OVERRUN_CLR);
    end
  end

`ifdef AUD_PEAK_EN
  logic [DATA_WIDTH-2:0] left_mag_c, right_mag_c;

  // Two's-complement magnitude, saturating the most negative code
  function automatic logic [DATA_WIDTH-2:0] mag(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] n;
    n = -s;
    if (!s[DATA_WIDTH-1])    mag = s[DATA_WIDTH-2:0];
    else if (n[DATA_WIDTH-1]) mag = '1;
    else                     mag = n[DATA_WIDTH-2:0];
  endfunction

  // Magnitudes of the frame currently held
  always_comb begin
    left_mag_c  = mag(LEFT_DATA);
    right_mag_c = mag(RIGHT_DATA);
  end

  // Peak hold updated on each consumer-accepted frame; clear wins
  always_ff @(posedge CLK) begin
    if (!RESET_N || PEAK_CLR) begin
      LEFT_PEAK  <= '0;
      RIGHT_PEAK <= '0;
    end else if (SAMPLE_VALID && SAMPLE_READY) begin
      if (left_mag_c > LEFT_PEAK)   LEFT_PEAK  <= left_mag_c;
      if (right_mag_c > RIGHT_PEAK) RIGHT_PEAK <= right_mag_c;
    end
  end
`endif

endmodule

// File: doc/audio_adc_deserializer.md
Name: audio_adc_deserializer

Overview:
- Parametrised serial-audio ADC receiver. Successor to the fixed 16-bit capture block.
- Runs entirely in the system clock domain: it oversamples AUD_BCLK, AUD_ADC_LRCK and AUD_ADC_DATA rather than clocking on BCLK.
- Deserialises left and right words of configurable width in I2S or left-justified framing.
- Presents completed stereo frames on a valid/ready interface to downstream visualiser logic, with overrun detection.

Parameters:
- DATA_WIDTH, 16: bits captured per channel word, MSB first.
- I2S_MODE, 1: 1 = one BCLK delay after each LRCK transition; 0 = left-justified (MSB on first BCLK).
- SYNC_STAGES, 2: synchroniser depth for the three audio inputs. Minimum 2.

Ports:
- CLK  in  1  system clock; must be at least 4x AUD_BCLK.
- RESET_N  in  1  synchronous, active-low reset.
- AUD_BCLK  in  1  codec bit clock (asynchronous).
- AUD_ADC_LRCK  in  1  codec frame clock: 1 = left channel, 0 = right channel.
- AUD_ADC_DATA  in  1  codec serial data.
- LEFT_DATA  out  DATA_WIDTH  left sample of the held frame.
- RIGHT_DATA  out  DATA_WIDTH  right sample of the held frame.
- SAMPLE_VALID  out  1  held frame is valid.
- SAMPLE_READY  in  1  consumer accepts the frame.
- OVERRUN  out  1  sticky: a frame was dropped.
- OVERRUN_CLR  in  1  clears OVERRUN.

Behaviour:
- Reset: one clock, synchronous, active-low. While RESET_N=0 on a CLK edge, all outputs go to 0, synchronisers clear, and the FSM enters ALIGN. Reset mid-word discards the partial data.
- Synchronisation: each input passes through SYNC_STAGES flops.
- BCLK edge: bclk_rise = synced BCLK is 1 and its previous value was 0. All serial activity happens only on CLK cycles with bclk_rise.
- LRCK sampling: lrck is sampled on bclk_rise. A slot boundary occurs when the sampled lrck differs from the previously sampled value.
- FSM states:
  - ALIGN: ignore data until the first slot boundary, then go to SKIP (I2S_MODE=1) or SHIFT (I2S_MODE=0).
  - SKIP: consume exactly one bclk_rise, then go to SHIFT. In left-justified mode the boundary bit itself is the MSB and is shifted.
  - SHIFT: shift AUD_ADC_DATA into a DATA_WIDTH register, MSB first, incrementing bit_cnt. At bit_cnt = DATA_WIDTH the word commits and the FSM goes to WAIT.
  - WAIT: ignore trailing slot bits until the next slot boundary, then go to SKIP/SHIFT.
- Short slot: a boundary arriving in SHIFT before DATA_WIDTH bits commits the word with the missing LSBs zero-filled. The new slot starts on that same bclk_rise.
- Commit routing: a word from lrck=1 goes to a left staging register and sets left_ok. A word from lrck=0, when left_ok=1, forms a frame and clears left_ok. A right word without a preceding left word in the same frame is discarded.
- Frame output: a frame forms on CLK cycle N; LEFT_DATA, RIGHT_DATA and SAMPLE_VALID update on the CLK edge ending cycle N (latency 1 CLK).
- Handshake: SAMPLE_VALID stays high and data stays stable until SAMPLE_VALID && SAMPLE_READY on a CLK edge. SAMPLE_VALID then drops next cycle unless a new frame forms that same cycle. In that case the new frame loads and SAMPLE_VALID stays 1.
- Overrun: a frame forms while SAMPLE_VALID=1 and SAMPLE_READY=0. The new frame is dropped, held data is unchanged, and OVERRUN is set.
- OVERRUN_CLR: clears OVERRUN. If an overrun occurs on the same cycle as OVERRUN_CLR, OVERRUN remains set (set wins).
- Widths: bit_cnt is $clog2(DATA_WIDTH+1) bits. Slots longer than DATA_WIDTH are truncated (extra LSBs ignored).

Optional Feature:
- Macro: AUD_PEAK_EN.
- When defined, adds:
  - Ports LEFT_PEAK and RIGHT_PEAK (out, DATA_WIDTH-1), plus PEAK_CLR (in, 1).
  - On each accepted frame, each peak register updates to max(peak, |sample|). Samples are two's complement. The magnitude of the most negative value saturates to 2^(DATA_WIDTH-1)-1.
  - PEAK_CLR zeroes both peaks. It has priority over an update on the same cycle.
  - Reset value of both peaks is 0.
- When undefined: no extra ports or logic. Behaviour is otherwise identical.

Test Plan:
- I2S, DATA_WIDTH=16, 32-bit slots, left=0x1234, right=0xABCD, READY=1 -> one SAMPLE_VALID pulse with LEFT_DATA=0x1234, RIGHT_DATA=0xABCD, asserted 1 CLK after the right word's 16th bit.
- Left-justified (I2S_MODE=0), same stream shifted one BCLK earlier -> identical output words. The same stream into I2S_MODE=1 -> words shifted by one bit (0x2468/0x579A pattern check).
- READY=0 for 3 frames -> first frame held stable, OVERRUN=1 after frame 2, held data still the first frame. OVERRUN_CLR pulse -> OVERRUN=0.
- 12-bit slots with DATA_WIDTH=16, left=0xFFF -> LEFT_DATA=0xFFF0 (zero-filled LSBs). 24-bit slots -> top 16 bits only.
- RESET_N low mid right-word, then released -> no frame emitted until a full left+right pair after the next LRCK boundary. All outputs 0 during reset.
- AUD_PEAK_EN: left samples 0x0100, 0xFF00, 0x8000 -> LEFT_PEAK 0x0100, 0x0100, 0x7FFF. PEAK_CLR -> 0.
